// File: rtl/stagger_pkg.sv
// stagger_pkg: types and constants for the staggered enable sequencer.
//   stg_state_e  : clkB sequencer state (IDLE/RUN/ACK)
//   MODE_SHRINK  : mode 0, enables drop off from the LSB end
//   MODE_GROW    : mode 1, enables drop off from the MSB end
//   N_CH_* and HOLD_* : legal parameter ranges
package stagger_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } stg_state_e;

  localparam logic MODE_SHRINK = 1'b0;
  localparam logic MODE_GROW   = 1'b1;

  localparam int N_CH_MIN = 2;
  localparam int N_CH_MAX = 16;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 255;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop level synchroniser for a single slowly-changing bit.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both flops
//   d     : input from the foreign domain
//   q     : synchronised output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/staggered_enable_ctrl.sv
// staggered_enable_ctrl: a clkA trigger launches a staggered thermometer
// enable sequence in clkB; completion is handed back to clkA.
//   clkA, clkB : trigger / sequence clocks
//   rst_n      : async active-low reset for both domains
//   trg, mode  : clkA trigger (level) and pattern select sampled with it
//   ena_a      : clkA enable (same as busy_a)
//   busy_a     : sequence in flight
//   done_a     : one-cycle completion pulse
//   ena_b      : N_CH staggered clkB enables
//   overrun_a  : sticky "trg while busy" flag, only with STAGGER_OVERRUN_EN
// Handshake is toggle based: req_tgl (A->B) and ack_tgl (B->A), each through
// sync_2ff plus an edge detector.
module staggered_enable_ctrl
  import stagger_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int HOLD = 1
) (
  input  logic            clkA,
  input  logic            clkB,
  input  logic            rst_n,
  input  logic            trg,
  input  logic            mode,
  output logic            ena_a,
  output logic            busy_a,
  output logic            done_a,
  output logic [N_CH-1:0] ena_b
`ifdef STAGGER_OVERRUN_EN
  ,
  output logic            overrun_a
`endif
);

  localparam int KW = $clog2(N_CH + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  // ---------------- clkA domain ----------------
  logic mode_q, req_tgl, ack_s, ack_d, ack_edge, accept;

  assign ack_edge = ack_s ^ ack_d;
  // The done_a cycle also blocks a trigger, so a new sequence always needs
  // trg seen with busy_a=0 after the pulse.
  assign accept   = trg && !busy_a && !done_a;
  assign ena_a    = busy_a;

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      busy_a  <= 1'b0;
      done_a  <= 1'b0;
      mode_q  <= MODE_SHRINK;
      req_tgl <= 1'b0;
      ack_d   <= 1'b0;
    end else begin
      ack_d  <= ack_s;
      done_a <= ack_edge;
      if (ack_edge) begin
        busy_a <= 1'b0;
      end else if (accept) begin
        busy_a  <= 1'b1;
        mode_q  <= mode;
        req_tgl <= ~req_tgl;
      end
    end
  end

`ifdef STAGGER_OVERRUN_EN
  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n)             overrun_a <= 1'b0;
    else if (trg && busy_a) overrun_a <= 1'b1;
  end
`endif

  // ---------------- clkB domain ----------------
  logic              req_s, req_d, start;
  logic              mode_b, mode_b_nxt, ack_tgl, ack_tgl_nxt;
  stg_state_e        st, st_nxt;
  logic [KW-1:0]     k, k_nxt;
  logic [HW-1:0]     hcnt, hcnt_nxt;
  logic [N_CH-1:0]   ena_nxt;

  sync_2ff u_req_sync (.clk(clkB), .rst_n(rst_n), .d(req_tgl), .q(req_s));
  sync_2ff u_ack_sync (.clk(clkA), .rst_n(rst_n), .d(ack_tgl), .q(ack_s));

  assign start = req_s ^ req_d;

  always_comb begin
    st_nxt      = st;
    k_nxt       = k;
    hcnt_nxt    = hcnt;
    mode_b_nxt  = mode_b;
    ack_tgl_nxt = ack_tgl;
    unique case (st)
      IDLE: if (start) begin
        st_nxt     = RUN;
        k_nxt      = KW'(1);
        hcnt_nxt   = '0;
        mode_b_nxt = mode_q;   // mode_q is stable while busy_a
      end
      RUN: begin
        if (hcnt == HW'(HOLD - 1)) begin
          hcnt_nxt = '0;
          if (k == KW'(N_CH)) begin
            st_nxt = ACK;
            k_nxt  = '0;
          end else begin
            k_nxt = k + 1'b1;
          end
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      ACK: begin
        st_nxt      = IDLE;
        ack_tgl_nxt = ~ack_tgl;
      end
      default: st_nxt = IDLE;
    endcase

    // Decode from next-state values so the registered ena_b lines up
    // exactly with the RUN cycles of each step.
    ena_nxt = '0;
    if (st_nxt == RUN) begin
      for (int i = 0; i < N_CH; i++) begin
        if (mode_b_nxt == MODE_GROW) ena_nxt[i] = (i <= N_CH - int'(k_nxt));
        else                         ena_nxt[i] = (i + 1 >= int'(k_nxt));
      end
    end
  end

  always_ff @(posedge clkB or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      k       <= '0;
      hcnt    <= '0;
      mode_b  <= MODE_SHRINK;
      ack_tgl <= 1'b0;
      req_d   <= 1'b0;
      ena_b   <= '0;
    end else begin
      st      <= st_nxt;
      k       <= k_nxt;
      hcnt    <= hcnt_nxt;
      mode_b  <= mode_b_nxt;
      ack_tgl <= ack_tgl_nxt;
      req_d   <= req_s;
      ena_b   <= ena_nxt;
    end
  end

endmodule

// File: tb/tb_staggered_enable_ctrl.sv
// tb_staggered_enable_ctrl: directed bench for staggered_enable_ctrl.
// Three instances: (4,1) main, (4,2) hold/grow pattern, (16,255) wrap.
module tb_staggered_enable_ctrl;

  logic clkA = 1'b0, clkB = 1'b0, rst_n = 1'b0;
  int   ha = 5, hb = 7;
  always #(ha) clkA = ~clkA;
  always #(hb) clkB = ~clkB;

  logic trg0 = 0, mode0 = 0, trg1 = 0, mode1 = 0, trg2 = 0, mode2 = 0;
  logic ena_a0, busy_a0, done_a0, ena_a1, busy_a1, done_a1, ena_a2, busy_a2, done_a2;
  logic [3:0]  ena_b0, ena_b1;
  logic [15:0] ena_b2;
`ifdef STAGGER_OVERRUN_EN
  logic ovr0, ovr1, ovr2;
`endif

  staggered_enable_ctrl #(.N_CH(4), .HOLD(1)) dut0 (
    .clkA(clkA), .clkB(clkB), .rst_n(rst_n), .trg(trg0), .mode(mode0),
    .ena_a(ena_a0), .busy_a(busy_a0), .done_a(done_a0), .ena_b(ena_b0)
`ifdef STAGGER_OVERRUN_EN
    , .overrun_a(ovr0)
`endif
  );
  staggered_enable_ctrl #(.N_CH(4), .HOLD(2)) dut1 (
    .clkA(clkA), .clkB(clkB), .rst_n(rst_n), .trg(trg1), .mode(mode1),
    .ena_a(ena_a1), .busy_a(busy_a1), .done_a(done_a1), .ena_b(ena_b1)
`ifdef STAGGER_OVERRUN_EN
    , .overrun_a(ovr1)
`endif
  );
  staggered_enable_ctrl #(.N_CH(16), .HOLD(255)) dut2 (
    .clkA(clkA), .clkB(clkB), .rst_n(rst_n), .trg(trg2), .mode(mode2),
    .ena_a(ena_a2), .busy_a(busy_a2), .done_a(done_a2), .ena_b(ena_b2)
`ifdef STAGGER_OVERRUN_EN
    , .overrun_a(ovr2)
`endif
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // dut0 monitors: sequences started (ena_b rising from zero) and done pulses
  int seq_cnt0 = 0, done_cnt0 = 0;
  logic [3:0] ena_prev0 = '0;
  always @(negedge clkB) begin
    if (ena_b0 != '0 && ena_prev0 == '0) seq_cnt0 <= seq_cnt0 + 1;
    ena_prev0 <= ena_b0;
  end
  always @(negedge clkA) if (done_a0) done_cnt0 <= done_cnt0 + 1;

  task automatic pulse_trg0(input logic m);
    int n = 0;
    do begin @(negedge clkA); n++; end while ((busy_a0 || done_a0) && n < 1000);
    mode0 = m; trg0 = 1'b1;
    @(negedge clkA);
    trg0 = 1'b0;
    chk("trg0_busy_set", busy_a0, 1'b1);
  endtask

  task automatic wait_ena0(input string tag);
    int n = 0;
    do begin @(negedge clkB); n++; end while (ena_b0 == '0 && n < 60);
    chk({tag, "_ena_seen"}, (ena_b0 != '0), 1'b1);
  endtask

  task automatic wait_done0(input string tag);
    int n = 0;
    do begin @(negedge clkA); n++; end while (!done_a0 && n < 1000);
    chk({tag, "_done"}, done_a0, 1'b1);
    chk({tag, "_busy_clr"}, busy_a0, 1'b0);
    chk({tag, "_ena_a_clr"}, ena_a0, 1'b0);
  endtask

  task automatic full_seq0(input string tag);
    logic [3:0] exp_s [5] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    pulse_trg0(1'b0);
    wait_ena0(tag);
    chk({tag, "_ena_a_run"}, ena_a0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clkB);
      chk($sformatf("%s_step%0d", tag, j + 1), ena_b0, exp_s[j]);
    end
    wait_done0(tag);
  endtask

  initial begin
    int d0, s0, n;
    logic [3:0] exp_g [9] = '{4'hF, 4'hF, 4'h7, 4'h7, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0};

    // reset state
    #3;
    chk("rst_busy", busy_a0, 1'b0);
    chk("rst_ena_a", ena_a0, 1'b0);
    chk("rst_done", done_a0, 1'b0);
    chk("rst_ena_b0", ena_b0, 4'h0);
    chk("rst_ena_b2", ena_b2, 16'h0);
`ifdef STAGGER_OVERRUN_EN
    chk("rst_overrun", ovr0, 1'b0);
`endif
    #30 rst_n = 1'b1;
    repeat (3) @(negedge clkA);

    // single shrinking sequence, HOLD=1
    d0 = done_cnt0; s0 = seq_cnt0;
    full_seq0("s1");
    repeat (5) @(negedge clkA);
    chk("s1_done_cnt", done_cnt0 - d0, 1);
    chk("s1_seq_cnt", seq_cnt0 - s0, 1);

    // growing pattern, HOLD=2
    @(negedge clkA); mode1 = 1'b1; trg1 = 1'b1;
    @(negedge clkA); trg1 = 1'b0;
    n = 0;
    do begin @(negedge clkB); n++; end while (ena_b1 == '0 && n < 60);
    for (int j = 0; j < 9; j++) begin
      if (j > 0) @(negedge clkB);
      chk($sformatf("s2_cyc%0d", j), ena_b1, exp_g[j]);
    end
    n = 0;
    do begin @(negedge clkA); n++; end while (!done_a1 && n < 1000);
    chk("s2_done", done_a1, 1'b1);
    chk("s2_busy_clr", busy_a1, 1'b0);

    // trg held through the whole sequence and the done_a cycle
    d0 = done_cnt0; s0 = seq_cnt0;
    @(negedge clkA); mode0 = 1'b1; trg0 = 1'b1;
    wait_done0("s3");
    @(negedge clkA); trg0 = 1'b0;
    chk("s3_no_restart", busy_a0, 1'b0);
`ifdef STAGGER_OVERRUN_EN
    chk("s3_overrun", ovr0, 1'b1);
`endif
    repeat (20) @(negedge clkA);
    chk("s3_busy_idle", busy_a0, 1'b0);
    chk("s3_done_cnt", done_cnt0 - d0, 1);
    chk("s3_seq_cnt", seq_cnt0 - s0, 1);

    // reset during step 2
    pulse_trg0(1'b0);
    wait_ena0("s4");
    @(negedge clkB);
    chk("s4_step2", ena_b0, 4'hE);
    d0 = done_cnt0;
    rst_n = 1'b0;
    #1;
    chk("s4_rst_ena_b", ena_b0, 4'h0);
    chk("s4_rst_busy", busy_a0, 1'b0);
`ifdef STAGGER_OVERRUN_EN
    chk("s4_rst_overrun", ovr0, 1'b0);
`endif
    #20 rst_n = 1'b1;
    repeat (30) @(negedge clkA);
    chk("s4_no_done", done_cnt0 - d0, 0);
    chk("s4_idle", busy_a0, 1'b0);
    full_seq0("s4r");
    repeat (5) @(negedge clkA);
    chk("s4_done_cnt", done_cnt0 - d0, 1);

    // clock-ratio sweep, back-to-back triggers
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin ha = 5;  hb = 17; end
      else        begin ha = 15; hb = 5;  end
      repeat (4) @(negedge clkA);
      d0 = done_cnt0; s0 = seq_cnt0;
      for (int t = 0; t < 3; t++) begin
        pulse_trg0(t[0]);
        wait_done0($sformatf("s5r%0dt%0d", r, t));
      end
      repeat (10) @(negedge clkA);
      chk($sformatf("s5r%0d_done_cnt", r), done_cnt0 - d0, 3);
      chk($sformatf("s5r%0d_seq_cnt", r), seq_cnt0 - s0, 3);
    end
    ha = 5; hb = 7;

    // N_CH=16, HOLD=255 wrap
    repeat (4) @(negedge clkA);
    mode2 = 1'b0; trg2 = 1'b1;
    @(negedge clkA); trg2 = 1'b0;
    n = 0;
    do begin @(negedge clkB); n++; end while (ena_b2 == '0 && n < 60);
    chk("s6_step1", ena_b2, 16'hFFFF);
    repeat (254) @(negedge clkB);
    chk("s6_step1_end", ena_b2, 16'hFFFF);
    @(negedge clkB);
    chk("s6_step2", ena_b2, 16'hFFFE);
    repeat (255 * 14) @(negedge clkB);
    chk("s6_step16", ena_b2, 16'h8000);
    repeat (254) @(negedge clkB);
    chk("s6_step16_end", ena_b2, 16'h8000);
    @(negedge clkB);
    chk("s6_ack", ena_b2, 16'h0000);
    n = 0;
    do begin @(negedge clkA); n++; end while (!done_a2 && n < 200);
    chk("s6_done", done_a2, 1'b1);
    chk("s6_busy_clr", busy_a2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
